// File: rtl/mem_debug_port.sv
// Byte-stream debug port: host commands write/read CPU memories
// and control the CPU reset line.
module mem_debug_port #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              i_we,
  output logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_wdata,
  output logic              d_we,
  output logic              d_re,
  output logic [ADDR_W-1:0] d_addr,
  output logic [DATA_W-1:0] d_wdata,
  input  logic [DATA_W-1:0] d_rdata,
  output logic              cpu_n_rst,
  input  logic              cpu_halt
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] GET_ADDR = 4'd1;
  localparam logic [3:0] GET_LO   = 4'd2;
  localparam logic [3:0] GET_HI   = 4'd3;
  localparam logic [3:0] WRITE    = 4'd4;
  localparam logic [3:0] READ     = 4'd5;
  localparam logic [3:0] RD_WAIT  = 4'd6;
  localparam logic [3:0] TX_LO    = 4'd7;
  localparam logic [3:0] TX_HI    = 4'd8;
  localparam logic [3:0] TX_BYTE  = 4'd9;

  localparam logic [7:0] C_WR_D   = 8'h01;
  localparam logic [7:0] C_RD_D   = 8'h02;
  localparam logic [7:0] C_WR_I   = 8'h03;
  localparam logic [7:0] C_RUN    = 8'h04;
  localparam logic [7:0] C_STATUS = 8'h05;
  localparam logic [7:0] C_STOP   = 8'h06;

  logic [3:0]        state;
  logic [3:0]        nxt;
  logic [7:0]        cmd;
  logic [7:0]        lo;
  logic [7:0]        rdata_hi;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              rx_fire;
  logic              nxt_rx;
  logic              nxt_tx;

  assign rx_fire = rx_valid && rx_ready;
  assign i_addr  = addr;
  assign d_addr  = addr;
  assign i_wdata = wdata;
  assign d_wdata = wdata;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:
        if (rx_fire) begin
          case (rx_data)
            C_WR_D, C_RD_D, C_WR_I: nxt = GET_ADDR;
            C_RUN, C_STOP:          nxt = IDLE;
            default:                nxt = TX_BYTE;
          endcase
        end
      GET_ADDR:
        if (rx_fire) nxt = (cmd == C_RD_D) ? READ : GET_LO;
      GET_LO:  if (rx_fire) nxt = GET_HI;
      GET_HI:  if (rx_fire) nxt = WRITE;
      WRITE:   nxt = IDLE;
      READ:    nxt = RD_WAIT;
      RD_WAIT: nxt = TX_LO;
      TX_LO:   if (tx_ready) nxt = TX_HI;
      TX_HI:   if (tx_ready) nxt = IDLE;
      TX_BYTE: if (tx_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state.
  assign nxt_rx = (nxt == IDLE) || (nxt == GET_ADDR) ||
                  (nxt == GET_LO) || (nxt == GET_HI);
  assign nxt_tx = (nxt == TX_LO) || (nxt == TX_HI) ||
                  (nxt == TX_BYTE);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= IDLE;
      rx_ready  <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      i_we      <= 1'b0;
      d_we      <= 1'b0;
      d_re      <= 1'b0;
      cpu_n_rst <= 1'b0;
      cmd       <= 8'h00;
      lo        <= 8'h00;
      rdata_hi  <= 8'h00;
      addr      <= '0;
      wdata     <= '0;
    end else begin
      state    <= nxt;
      rx_ready <= nxt_rx;
      tx_valid <= nxt_tx;
      i_we     <= 1'b0;
      d_we     <= 1'b0;
      d_re     <= 1'b0;
      case (state)
        IDLE:
          if (rx_fire) begin
            cmd <= rx_data;
            case (rx_data)
              C_WR_D, C_RD_D, C_WR_I: ;
              C_RUN:    cpu_n_rst <= 1'b1;
              C_STOP:   cpu_n_rst <= 1'b0;
              C_STATUS: tx_data <= {6'b0, cpu_halt, cpu_n_rst};
              default:  tx_data <= 8'hEE;
            endcase
          end
        GET_ADDR:
          if (rx_fire) begin
            addr <= ADDR_W'({{ADDR_W{1'b0}}, rx_data});
            if (cmd == C_RD_D) d_re <= 1'b1;
          end
        GET_LO:
          if (rx_fire) lo <= rx_data;
        GET_HI:
          if (rx_fire) begin
            wdata     <= {rx_data, lo};
            cpu_n_rst <= 1'b0;
            if (cmd == C_WR_I) i_we <= 1'b1;
            else               d_we <= 1'b1;
          end
        RD_WAIT: begin
          rdata_hi <= d_rdata[DATA_W-1:8];
          tx_data  <= d_rdata[7:0];
        end
        TX_LO:
          if (tx_ready) tx_data <= rdata_hi;
        TX_HI, TX_BYTE:
          if (tx_ready) tx_data <= 8'h00;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_debug_port.sv
// Directed bench for mem_debug_port with a small memory model
// answering reads one cycle after d_re.
module tb_mem_debug_port;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        i_we;
  logic [7:0]  i_addr;
  logic [15:0] i_wdata;
  logic        d_we;
  logic        d_re;
  logic [7:0]  d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata = 16'h0000;
  logic        cpu_n_rst;
  logic        cpu_halt = 1'b0;

  int tests = 0;
  int fails = 0;
  int d_we_cnt = 0;
  int i_we_cnt = 0;
  int d_re_cnt = 0;
  logic [15:0] mem [256];

  mem_debug_port #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .n_rst(n_rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .d_we(d_we), .d_re(d_re), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .cpu_n_rst(cpu_n_rst), .cpu_halt(cpu_halt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (d_we) mem[d_addr] <= d_wdata;
    if (d_re) d_rdata <= mem[d_addr];
  end

  always @(negedge clk) begin
    if (d_we) d_we_cnt++;
    if (i_we) i_we_cnt++;
    if (d_re) d_re_cnt++;
  end

  // Returns #1 after the edge on which the byte was accepted.
  task automatic send(input logic [7:0] b);
    int k;
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    k = 0;
    while (!rx_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (!rx_ready) begin
      fails++;
      $display("FAIL send_timeout: byte %h never accepted", b);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic recv(input logic [7:0] exp);
    int k;
    @(negedge clk);
    tx_ready = 1'b1;
    k = 0;
    while (!tx_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (!tx_valid || tx_data !== exp) begin
      fails++;
      $display("FAIL recv: got %h valid %b expected %h",
               tx_data, tx_valid, exp);
    end
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({rx_ready, tx_valid, cpu_n_rst, i_we, d_we, d_re}
        !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctl: got %b expected 000000",
        {rx_ready, tx_valid, cpu_n_rst, i_we, d_we, d_re});
    end
    tests++;
    if ({tx_data, d_addr, i_addr, d_wdata, i_wdata} !== 56'h0) begin
      fails++;
      $display("FAIL reset_data: got %h expected 0",
        {tx_data, d_addr, i_addr, d_wdata, i_wdata});
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (rx_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_rx_rise: got %b expected 1", rx_ready);
    end
  endtask

  task automatic test_wr_rd_d();
    int c0;
    c0 = d_we_cnt;
    send(8'h01); send(8'h00); send(8'h34); send(8'h12);
    tests++;
    if ({d_we, i_we, d_addr, d_wdata} !== {2'b10, 8'h00, 16'h1234})
    begin
      fails++;
      $display("FAIL wr_d_pulse: got we %b%b a %h d %h exp 10 00 1234",
               d_we, i_we, d_addr, d_wdata);
    end
    @(posedge clk);
    #1;
    tests++;
    if (d_we !== 1'b0 || d_we_cnt != c0 + 1) begin
      fails++;
      $display("FAIL wr_d_once: got we %b cnt %0d expected 0 %0d",
               d_we, d_we_cnt - c0, 1);
    end
    send(8'h02); send(8'h00);
    tests++;
    if (d_re !== 1'b1 || tx_valid !== 1'b0) begin
      fails++;
      $display("FAIL rd_re: got re %b tv %b expected 1 0",
               d_re, tx_valid);
    end
    @(posedge clk);
    #1;
    tests++;
    if (d_re !== 1'b0 || tx_valid !== 1'b0) begin
      fails++;
      $display("FAIL rd_wait: got re %b tv %b expected 0 0",
               d_re, tx_valid);
    end
    @(posedge clk);
    #1;
    tests++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h34) begin
      fails++;
      $display("FAIL rd_latency: got tv %b %h expected 1 34",
               tx_valid, tx_data);
    end
    recv(8'h34);
    recv(8'h12);
    tests++;
    if (tx_valid !== 1'b0) begin
      fails++;
      $display("FAIL rd_done: got tv %b expected 0", tx_valid);
    end
  endtask

  task automatic test_wr_i();
    int d0, i0;
    d0 = d_we_cnt;
    i0 = i_we_cnt;
    send(8'h03); send(8'h05); send(8'hCD); send(8'hAB);
    tests++;
    if ({i_we, d_we, i_addr, i_wdata} !== {2'b10, 8'h05, 16'hABCD})
    begin
      fails++;
      $display("FAIL wr_i_pulse: got we %b%b a %h d %h exp 10 05 abcd",
               i_we, d_we, i_addr, i_wdata);
    end
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (cpu_n_rst !== 1'b0 || d_we_cnt != d0 || i_we_cnt != i0 + 1)
    begin
      fails++;
      $display("FAIL wr_i_side: got rst %b dwe %0d iwe %0d exp 0 0 1",
               cpu_n_rst, d_we_cnt - d0, i_we_cnt - i0);
    end
  endtask

  task automatic test_run_status();
    cpu_halt = 1'b1;
    send(8'h04);
    tests++;
    if (cpu_n_rst !== 1'b1 || tx_valid !== 1'b0) begin
      fails++;
      $display("FAIL run: got rst %b tv %b expected 1 0",
               cpu_n_rst, tx_valid);
    end
    send(8'h05);
    recv(8'h03);
    send(8'h06);
    tests++;
    if (cpu_n_rst !== 1'b0) begin
      fails++;
      $display("FAIL stop: got rst %b expected 0", cpu_n_rst);
    end
    send(8'h05);
    recv(8'h02);
    cpu_halt = 1'b0;
  endtask

  task automatic test_backpressure();
    int k;
    int bad;
    send(8'h02); send(8'h00);
    k = 0;
    while (!tx_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== 8'h34 || rx_ready !== 1'b0)
        bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL hold: got %0d bad cycles (tv %b %h rr %b) exp 0",
               bad, tx_valid, tx_data, rx_ready);
    end
    recv(8'h34);
    recv(8'h12);
  endtask

  task automatic test_bad_cmd();
    int d0, i0, r0;
    logic rst0;
    d0 = d_we_cnt;
    i0 = i_we_cnt;
    r0 = d_re_cnt;
    rst0 = cpu_n_rst;
    send(8'h7F);
    recv(8'hEE);
    tests++;
    if (d_we_cnt != d0 || i_we_cnt != i0 || d_re_cnt != r0 ||
        cpu_n_rst !== rst0) begin
      fails++;
      $display("FAIL bad_side: got strobes %0d rst %b expected 0 %b",
        d_we_cnt - d0 + i_we_cnt - i0 + d_re_cnt - r0,
        cpu_n_rst, rst0);
    end
    send(8'h01); send(8'h10); send(8'h22); send(8'h11);
    @(posedge clk);
    #1;
    tests++;
    if (mem[8'h10] !== 16'h1122 || d_we_cnt != d0 + 1) begin
      fails++;
      $display("FAIL bad_next: got mem %h cnt %0d expected 1122 1",
               mem[8'h10], d_we_cnt - d0);
    end
  endtask

  task automatic test_mid_reset();
    int d0;
    d0 = d_we_cnt;
    send(8'h01); send(8'h00); send(8'h34);
    @(negedge clk);
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if ({rx_ready, tx_valid, cpu_n_rst, d_we} !== 4'b0) begin
      fails++;
      $display("FAIL mid_rst: got %b expected 0000",
               {rx_ready, tx_valid, cpu_n_rst, d_we});
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (rx_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_rx: got %b expected 1", rx_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (d_we_cnt != d0) begin
      fails++;
      $display("FAIL mid_nowe: got %0d pulses expected 0",
               d_we_cnt - d0);
    end
    send(8'h01); send(8'h00); send(8'h78); send(8'h56);
    tests++;
    if (d_we !== 1'b1 || d_wdata !== 16'h5678) begin
      fails++;
      $display("FAIL mid_retry: got we %b d %h expected 1 5678",
               d_we, d_wdata);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    test_reset();
    test_wr_rd_d();
    test_wr_i();
    test_run_status();
    test_backpressure();
    test_bad_cmd();
    test_mid_reset();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_debug_port.md
MEM_DEBUG_PORT -- requirements
Module: mem_debug_port

Interface
REQ-001 Parameter ADDR_W, default 8, shall set the word-address width of both memory ports.
REQ-002 Parameter DATA_W, fixed at 16, shall set the word width of both memory ports.
REQ-003 clk  input  1  shall be the single clock; every register updates on its rising edge.
REQ-004 n_rst  input  1  shall be a synchronous, active-low reset, sampled only on the rising edge of clk.
REQ-005 rx_data  input  8  shall carry the host command byte.
REQ-006 rx_valid  input  1  shall mark rx_data as valid.
REQ-007 rx_ready  output  1  shall indicate the block accepts a byte; a byte transfers when rx_valid && rx_ready at a clock edge.
REQ-008 tx_data  output  8  shall carry the response byte to the host.
REQ-009 tx_valid  output  1  shall mark tx_data as valid.
REQ-010 tx_ready  input  1  shall indicate the host accepts a byte; a byte transfers when tx_valid && tx_ready at a clock edge.
REQ-011 i_we, i_addr[ADDR_W], i_wdata[16]  output  shall form the instruction-memory write port.
REQ-012 d_we, d_re, d_addr[ADDR_W], d_wdata[16]  output  shall form the data-memory access port.
REQ-013 d_rdata  input  16  shall carry read data, valid exactly one cycle after d_re.
REQ-014 cpu_n_rst  output  1  shall be the CPU reset, active-low.
REQ-015 cpu_halt  input  1  shall be the CPU halt flag.

Function
REQ-016 Commands (first byte) shall be: 0x01 WR_D addr lo hi; 0x02 RD_D addr; 0x03 WR_I addr lo hi; 0x04 RUN; 0x05 STATUS; 0x06 STOP.
REQ-017 Multi-byte data shall be little-endian; the addr byte shall be zero-extended or truncated to ADDR_W.
REQ-018 The FSM shall have states IDLE, GET_ADDR, GET_LO, GET_HI, WRITE, READ, RD_WAIT, TX_LO, TX_HI, TX_BYTE.
REQ-019 rx_ready shall be 1 only in IDLE, GET_ADDR, GET_LO and GET_HI.
REQ-020 Transitions: IDLE->GET_ADDR on 0x01/0x02/0x03; GET_ADDR->GET_LO (write commands) or READ (0x02); GET_LO->GET_HI->WRITE; WRITE->IDLE.
REQ-021 In WRITE, exactly one of i_we or d_we shall pulse for exactly one cycle, with address and data stable during the pulse.
REQ-022 A write command shall drive cpu_n_rst low in the WRITE cycle, and cpu_n_rst shall stay low until the next RUN.
REQ-023 READ shall pulse d_re for one cycle; RD_WAIT shall capture d_rdata; the block shall then send TX_LO (rdata[7:0]) followed by TX_HI (rdata[15:8]).
REQ-024 Each TX state shall hold tx_valid and tx_data stable until tx_ready, then advance on that edge; tx_valid shall be 0 in every other state.
REQ-025 RUN shall set cpu_n_rst=1 one cycle after the command byte is accepted, shall return to IDLE, and shall send no response.
REQ-026 STOP shall set cpu_n_rst=0 and return to IDLE.
REQ-027 STATUS shall send one byte via TX_BYTE: {6'b0, cpu_halt, cpu_n_rst}, with cpu_halt sampled in the cycle the command byte is accepted.
REQ-028 Any other command byte shall send 0xEE via TX_BYTE and shall leave memory and cpu_n_rst unchanged.
REQ-029 RD_D shall be legal while the CPU runs; the block does not arbitrate, and the memory gives the debug port priority.
REQ-030 Command-to-write-pulse latency shall be 1 cycle after the hi byte is accepted; RD_D shall present the first tx_valid 3 cycles after the addr byte is accepted.

Reset
REQ-031 On n_rst=0 at a clock edge, the FSM shall go to IDLE and the block shall set cpu_n_rst=0, i_we=d_we=d_re=0, tx_valid=0, tx_data=0, rx_ready=0, and all address, data and captured registers to 0.
REQ-032 rx_ready shall rise in the first cycle after n_rst returns to 1.
REQ-033 A reset in the middle of a command shall discard the partial command, and no write pulse shall occur.

Verification
REQ-034 Send 01 00 34 12 -> one-cycle d_we with d_addr=0, d_wdata=0x1234; send 02 00 -> tx bytes 0x34 then 0x12.
REQ-035 Send 03 05 CD AB -> i_we with i_addr=5, i_wdata=0xABCD; cpu_n_rst stays 0; d_we never asserts.
REQ-036 Send 04, hold cpu_halt=1, send 05 -> cpu_n_rst=1 and response 0x03; then send 06 and 05 -> response 0x02.
REQ-037 Hold tx_ready=0 for 10 cycles during a RD_D response -> tx_data stays 0x34 with tx_valid=1 throughout, and rx_ready=0.
REQ-038 Send 0x7F -> response 0xEE with no memory strobes; the next command executes normally.
REQ-039 Assert n_rst=0 for 1 cycle after 01 00 34 -> no d_we; then send 01 00 78 56 -> d_wdata=0x5678.
